// File: rtl/fifo_reader_if.sv
// Purpose: bundles the FIFO read port and the downstream valid/ready stream of fifo_reader.
// Latency: wires only, no state.
// Backpressure: out_ready from the consumer throttles fifo_read_en inside the reader.
interface fifo_reader_if #(
    parameter type T = logic [31:0]
);
    logic       fifo_empty;
    logic       fifo_read_en;
    T           fifo_read_data;
    logic       out_valid;
    T           out_data;
    logic       out_ready;
    logic       flush;
    logic [1:0] count;

    // Reader side: drives the FIFO read enable and the output stream.
    modport master (
        input  fifo_empty,
        input  fifo_read_data,
        input  out_ready,
        input  flush,
        output fifo_read_en,
        output out_valid,
        output out_data,
        output count
    );

    // Environment side: FIFO plus consumer.
    modport slave (
        output fifo_empty,
        output fifo_read_data,
        output out_ready,
        output flush,
        input  fifo_read_en,
        input  out_valid,
        input  out_data,
        input  count
    );
endinterface

// File: rtl/fifo_reader.sv
// Purpose: drains a registered-read FIFO into a valid/ready stream through a 2-entry skid buffer.
// Latency: read issued in cycle N is presented on out_valid/out_data in cycle N+2; 1 entry/cycle sustained.
// Backpressure: reads stop once buffered + in-flight entries would exceed 2 after this cycle's pop.
module fifo_reader #(
    parameter type T = logic [31:0]
) (
    input  logic          clk,
    input  logic          reset,
    fifo_reader_if.master bus
);

    // Two-slot in-order buffer; head/tail are 1-bit indices that wrap naturally.
    T           mem [2];
    logic [1:0] occ;
    logic       inflight;
    logic       head;
    logic       tail;

    logic       pop;
    logic [2:0] level;

    // Read issue: room must exist after this cycle's pop for the entry that returns next cycle.
    always_comb begin
        pop              = bus.out_valid & bus.out_ready;
        level            = {1'b0, occ} + {2'b00, inflight};
        bus.fifo_read_en = reset & ~bus.flush & ~bus.fifo_empty
                           & (level < (3'd2 + {2'b00, pop}));
    end

    // Output view: head slot straight from registered storage, so it is stable while stalled.
    always_comb begin
        bus.out_valid = (occ != 2'd0);
        bus.out_data  = mem[head];
        bus.count     = occ;
    end

    // Buffer state: capture returning data at the tail, retire at the head; flush empties everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem[0]   <= '0;
            mem[1]   <= '0;
            occ      <= 2'd0;
            inflight <= 1'b0;
            head     <= 1'b0;
            tail     <= 1'b0;
        end else if (bus.flush) begin
            // In-flight data arriving now is dropped; pops this cycle are ignored.
            occ      <= 2'd0;
            inflight <= 1'b0;
            head     <= 1'b0;
            tail     <= 1'b0;
        end else begin
            if (inflight) begin
                mem[tail] <= bus.fifo_read_data;
                tail      <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            occ      <= occ + {1'b0, inflight} - {1'b0, pop};
            inflight <= bus.fifo_read_en;
        end
    end

endmodule
